// File: rtl/ls_ex.sv
// ls_ex -- load/store execution unit.
//
// Takes one memory request at a time from the load/store queue and moves it
// through a byte-wide RAM port, one byte per granted cycle, little-endian.
// Loads are assembled, extended and broadcast on the CDB with a one-cycle
// valid pulse; stores finish silently once their last byte is written.
//
// Ports:
//   clk, rst (async, active-low), rdy (global stall: everything holds)
//   *_from_ls / full_sign_to_ls   request in, busy back-pressure out
//   *_to_cdb                      load result broadcast
//   rollback_sign_from_rob        flush: drops in-flight loads only
//   mem_req/grant, mem_a/dout/wr/din   byte-wide RAM port via arbiter
//   io_buffer_full                holds stores to the I/O region

`ifndef LS_EX_DEFS
`define LS_EX_DEFS
`define OPNUM_TYPE  [5:0]
`define ADDR_TYPE   [31:0]
`define DATA_TYPE   [31:0]
`define ROB_ID_TYPE [4:0]
`define INVALID_ROB 5'd16
`define OPNUM_LB    6'd1
`define OPNUM_LH    6'd2
`define OPNUM_LW    6'd3
`define OPNUM_LBU   6'd4
`define OPNUM_LHU   6'd5
`define OPNUM_SB    6'd6
`define OPNUM_SH    6'd7
`define OPNUM_SW    6'd8
`endif

module ls_ex #(
   parameter logic [31:0] RAM_IO_ADDR = 32'h30000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                enable_sign_from_ls,
   input  logic `OPNUM_TYPE    opnum_from_ls,
   input  logic `ADDR_TYPE     addr_from_ls,
   input  logic `DATA_TYPE     store_data_from_ls,
   input  logic `ROB_ID_TYPE   rob_id_from_ls,
   output logic                full_sign_to_ls,
   output logic                valid_sign_to_cdb,
   output logic `ROB_ID_TYPE   rob_id_to_cdb,
   output logic `DATA_TYPE     data_to_cdb,
   input  logic                rollback_sign_from_rob,
   output logic                mem_req_sign_to_mc,
   input  logic                mem_grant_sign_from_mc,
   output logic `ADDR_TYPE     mem_a,
   output logic [7:0]          mem_dout,
   output logic                mem_wr,
   input  logic [7:0]          mem_din,
   input  logic                io_buffer_full
);

   typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

   state_t            state, state_nxt;
   logic `OPNUM_TYPE  op_q;
   logic `ADDR_TYPE   addr_q;
   logic `DATA_TYPE   sdata_q;
   logic `DATA_TYPE   ld_buf;     // load bytes captured so far
   logic `DATA_TYPE   ld_word;    // ld_buf with the byte arriving this cycle merged in
   logic `DATA_TYPE   ld_ext;
   logic [2:0]        idx;        // bytes already presented
   logic [2:0]        nbytes;
   logic              rd_pend;    // a read was presented last cycle; mem_din holds it now
   logic [1:0]        rd_idx;
   logic              is_load_in, is_load_q;
   logic              io_stall, present, last_byte, accept;

   assign is_load_in = (opnum_from_ls <= `OPNUM_LHU);
   assign is_load_q  = (op_q <= `OPNUM_LHU);

   always_comb begin
      nbytes = 3'd4;
      case (op_q)
         `OPNUM_LB, `OPNUM_LBU, `OPNUM_SB: nbytes = 3'd1;
         `OPNUM_LH, `OPNUM_LHU, `OPNUM_SH: nbytes = 3'd2;
         default:                          nbytes = 3'd4;
      endcase
   end

   // I/O writes go through a buffer; while it is full the store must wait.
   assign io_stall  = !is_load_q && (addr_q >= RAM_IO_ADDR) && io_buffer_full;
   assign present   = (state == ACCESS) && mem_grant_sign_from_mc && rdy && !io_stall;
   assign last_byte = ((idx + 3'd1) == nbytes);
   // A load arriving together with a flush belongs to the squashed path.
   assign accept    = (state == IDLE) && enable_sign_from_ls && rdy &&
                      !(rollback_sign_from_rob && is_load_in);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     state <= IDLE;
      else if (rdy) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (accept) state_nxt = ACCESS;
         ACCESS: begin
            if (rollback_sign_from_rob && is_load_q)
               state_nxt = IDLE;
            else if (present && last_byte)
               state_nxt = is_load_q ? FINISH : IDLE;
         end
         FINISH: state_nxt = IDLE;  // either broadcast or flushed
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- memory port ----------------
   assign full_sign_to_ls    = (state != IDLE);
   assign mem_req_sign_to_mc = (state == ACCESS);
   assign mem_wr             = present && !is_load_q;
   assign mem_a              = present ? (addr_q + {29'd0, idx}) : '0;

   always_comb begin
      mem_dout = 8'h00;
      if (present && !is_load_q) begin
         case (idx[1:0])
            2'd0: mem_dout = sdata_q[7:0];
            2'd1: mem_dout = sdata_q[15:8];
            2'd2: mem_dout = sdata_q[23:16];
            default: mem_dout = sdata_q[31:24];
         endcase
      end
   end

   // ---------------- load assembly ----------------
   always_comb begin
      ld_word = ld_buf;
      case (rd_idx)
         2'd0: ld_word[7:0]   = mem_din;
         2'd1: ld_word[15:8]  = mem_din;
         2'd2: ld_word[23:16] = mem_din;
         default: ld_word[31:24] = mem_din;
      endcase
   end

   always_comb begin
      ld_ext = ld_word;
      case (op_q)
         `OPNUM_LB:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
         `OPNUM_LH:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
         `OPNUM_LBU: ld_ext = {24'd0, ld_word[7:0]};
         `OPNUM_LHU: ld_ext = {16'd0, ld_word[15:0]};
         default:    ld_ext = ld_word;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q              <= '0;
         addr_q            <= '0;
         sdata_q           <= '0;
         idx               <= '0;
         rd_pend           <= 1'b0;
         rd_idx            <= '0;
         ld_buf            <= '0;
         valid_sign_to_cdb <= 1'b0;
         data_to_cdb       <= '0;
         rob_id_to_cdb     <= `INVALID_ROB;
      end else if (rdy) begin
         valid_sign_to_cdb <= 1'b0;
         // mem_din answers last cycle's address even if grant has since dropped
         rd_pend <= present && is_load_q;
         if (present) begin
            idx    <= idx + 3'd1;
            rd_idx <= idx[1:0];
         end
         if (rd_pend) ld_buf <= ld_word;
         if (accept) begin
            op_q          <= opnum_from_ls;
            addr_q        <= addr_from_ls;
            sdata_q       <= store_data_from_ls;
            idx           <= '0;
            ld_buf        <= '0;
            rob_id_to_cdb <= rob_id_from_ls;
         end
         if (state == FINISH && !rollback_sign_from_rob) begin
            valid_sign_to_cdb <= 1'b1;
            data_to_cdb       <= ld_ext;
         end
      end
   end

endmodule

// File: tb/tb_ls_ex.sv
// Testbench for ls_ex: byte RAM model, load/write scoreboards, directed
// timing cases followed by a randomized mix under random arbiter grant.
`timescale 1ns/1ps

`ifndef LS_EX_DEFS
`define LS_EX_DEFS
`define OPNUM_TYPE  [5:0]
`define ADDR_TYPE   [31:0]
`define DATA_TYPE   [31:0]
`define ROB_ID_TYPE [4:0]
`define INVALID_ROB 5'd16
`define OPNUM_LB    6'd1
`define OPNUM_LH    6'd2
`define OPNUM_LW    6'd3
`define OPNUM_LBU   6'd4
`define OPNUM_LHU   6'd5
`define OPNUM_SB    6'd6
`define OPNUM_SH    6'd7
`define OPNUM_SW    6'd8
`endif

module tb_ls_ex;

   logic              clk = 1'b0;
   logic              rst, rdy, enable, rollback, grant_dir, rnd_en, io_full;
   logic              rnd_g = 1'b0;
   logic              grant;
   logic `OPNUM_TYPE  opnum;
   logic `ADDR_TYPE   addr;
   logic `DATA_TYPE   sdata;
   logic `ROB_ID_TYPE rob;
   logic              full, valid, mem_req, mem_wr;
   logic `ROB_ID_TYPE rob_cdb;
   logic `DATA_TYPE   data_cdb;
   logic `ADDR_TYPE   mem_a;
   logic [7:0]        mem_dout;
   logic [7:0]        mem_din = 8'h00;

   assign grant = rnd_en ? rnd_g : grant_dir;

   always #5 clk = ~clk;

   ls_ex dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .enable_sign_from_ls(enable), .opnum_from_ls(opnum), .addr_from_ls(addr),
      .store_data_from_ls(sdata), .rob_id_from_ls(rob),
      .full_sign_to_ls(full), .valid_sign_to_cdb(valid),
      .rob_id_to_cdb(rob_cdb), .data_to_cdb(data_cdb),
      .rollback_sign_from_rob(rollback),
      .mem_req_sign_to_mc(mem_req), .mem_grant_sign_from_mc(grant),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .io_buffer_full(io_full)
   );

   typedef struct { logic `ROB_ID_TYPE rob; logic `DATA_TYPE data; } ld_t;
   typedef struct { logic `ADDR_TYPE addr; logic [7:0] data; } wr_t;

   ld_t        exp_ld[$];
   wr_t        exp_wr[$];
   logic [7:0] wmem [logic [31:0]];
   int         n_chk = 0, n_err = 0;
   int         vcnt = 0, wr_cnt = 0;
   ld_t        mon_l;
   wr_t        mon_w;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Initial RAM contents: a few fixed bytes, a hash elsewhere; writes overlay.
   function automatic logic [7:0] rd(input logic [31:0] a);
      if (wmem.exists(a)) return wmem[a];
      case (a)
         32'h100: return 8'h80;
         32'h200: return 8'h11;
         32'h201: return 8'h22;
         32'h202: return 8'h33;
         32'h203: return 8'h44;
         default: return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic `DATA_TYPE ld_model(input logic `OPNUM_TYPE op, input logic `ADDR_TYPE a);
      logic [31:0] w;
      w = {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
      case (op)
         `OPNUM_LB:  return {{24{w[7]}}, w[7:0]};
         `OPNUM_LH:  return {{16{w[15]}}, w[15:0]};
         `OPNUM_LBU: return {24'd0, w[7:0]};
         `OPNUM_LHU: return {16'd0, w[15:0]};
         default:    return w;
      endcase
   endfunction

   function automatic int nb(input logic `OPNUM_TYPE op);
      if (op == `OPNUM_LB || op == `OPNUM_LBU || op == `OPNUM_SB) return 1;
      if (op == `OPNUM_LH || op == `OPNUM_LHU || op == `OPNUM_SH) return 2;
      return 4;
   endfunction

   // RAM read port: data for the address presented during the cycle just ended.
   always @(posedge clk) mem_din <= rd(mem_a);

   always begin
      @(posedge clk); #1;
      rnd_g = 1'($urandom_range(0, 1));
   end

   // Monitor: commits writes to the RAM model and drains both scoreboards.
   always @(negedge clk) begin
      if (mem_wr) begin
         wmem[mem_a] = mem_dout;
         wr_cnt++;
         chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
         if (exp_wr.size() != 0) begin
            mon_w = exp_wr.pop_front();
            chk("wr_addr", mem_a, mon_w.addr);
            chk("wr_data", {24'd0, mem_dout}, {24'd0, mon_w.data});
         end
      end
      if (valid) begin
         vcnt++;
         chk("valid_expected", 32'(exp_ld.size() != 0), 32'd1);
         if (exp_ld.size() != 0) begin
            mon_l = exp_ld.pop_front();
            chk("ld_data", data_cdb, mon_l.data);
            chk("ld_rob", {27'd0, rob_cdb}, {27'd0, mon_l.rob});
         end
      end
   end

   // Drives a request once the unit is free; returns at the start of cycle 1.
   task automatic issue(input logic `OPNUM_TYPE op, input logic `ADDR_TYPE a,
                        input logic `DATA_TYPE d, input logic `ROB_ID_TYPE r, input bit expect_out);
      int w = 0;
      while (full && w < 100) begin @(negedge clk); w++; end
      chk("issue_wait", {31'd0, full}, 32'd0);
      if (expect_out) begin
         if (op <= `OPNUM_LHU) exp_ld.push_back('{rob: r, data: ld_model(op, a)});
         else for (int i = 0; i < nb(op); i++)
            exp_wr.push_back('{addr: a + 32'(i), data: d[8*i +: 8]});
      end
      enable = 1'b1; opnum = op; addr = a; sdata = d; rob = r;
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_full"},  {31'd0, full},    32'd0);
      chk({tag, "_valid"}, {31'd0, valid},   32'd0);
      chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
      chk({tag, "_wr"},    {31'd0, mem_wr},  32'd0);
      chk({tag, "_a"},     mem_a,            32'd0);
      chk({tag, "_dout"},  {24'd0, mem_dout}, 32'd0);
      chk({tag, "_data"},  data_cdb,         32'd0);
      chk({tag, "_rob"},   {27'd0, rob_cdb}, {27'd0, `INVALID_ROB});
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vk, v0, w0, wt;
      logic [7:0] keep;
      rst = 1'b0; rdy = 1'b1; enable = 1'b0; rollback = 1'b0; grant_dir = 1'b1;
      rnd_en = 1'b0; io_full = 1'b0; opnum = '0; addr = '0; sdata = '0; rob = '0;

      repeat (3) @(posedge clk); #1;
      chk_reset_outs("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // LB / LBU from 0x100 (0x80): sign vs zero extension, valid in cycle 3
      issue(`OPNUM_LB, 32'h100, 32'd0, 5'd3, 1'b1);
      vk = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); if (valid && vk == 0) vk = k;
         @(posedge clk); #1;
      end
      chk("lb_valid_cyc", 32'(vk), 32'd3);
      chk("lb_data", data_cdb, 32'hFFFFFF80);
      issue(`OPNUM_LBU, 32'h100, 32'd0, 5'd4, 1'b1);
      repeat (4) begin @(posedge clk); #1; end
      chk("lbu_data", data_cdb, 32'h00000080);

      // LW 0x200: one address per cycle 1..4, result and free in cycle 6,
      // and a back-to-back LB accepted in that same cycle
      issue(`OPNUM_LW, 32'h200, 32'd0, 5'd5, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) chk("lw_mem_a", mem_a, 32'h200 + 32'(k - 1));
         if (k == 6) begin
            chk("lw_valid_c6", {31'd0, valid}, 32'd1);
            chk("lw_full_c6", {31'd0, full}, 32'd0);
            chk("lw_data", data_cdb, 32'h44332211);
         end
         if (k < 6) begin @(posedge clk); #1; end
      end
      issue(`OPNUM_LB, 32'h100, 32'd0, 5'd6, 1'b1);
      vk = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); if (valid && vk == 0) vk = k;
         @(posedge clk); #1;
      end
      chk("b2b_valid_cyc", 32'(vk), 32'd3);

      // SH 0x300 with grant low in cycles 1-2: writes in cycles 3 and 4 only
      v0 = vcnt;
      issue(`OPNUM_SH, 32'h300, 32'h0000ABCD, 5'd7, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         grant_dir = (k >= 3);
         @(negedge clk);
         chk("sh_wr_cyc", {31'd0, mem_wr}, 32'(k == 3 || k == 4));
         @(posedge clk); #1;
      end
      grant_dir = 1'b1;
      chk("sh_mem", {16'd0, rd(32'h301), rd(32'h300)}, 32'h0000ABCD);
      chk("sh_no_valid", 32'(vcnt - v0), 32'd0);

      // Rollback of an in-flight LW in cycle 2
      v0 = vcnt;
      issue(`OPNUM_LW, 32'h200, 32'd0, 5'd8, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         rollback = (k == 2);
         @(negedge clk);
         if (k == 3) chk("rb_lw_req", {31'd0, mem_req}, 32'd0);
         @(posedge clk); #1;
      end
      chk("rb_lw_no_valid", 32'(vcnt - v0), 32'd0);

      // Rollback during a SW: all four bytes still written
      w0 = wr_cnt;
      issue(`OPNUM_SW, 32'h400, 32'hDEADBEEF, 5'd9, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         rollback = (k == 2);
         @(posedge clk); #1;
      end
      rollback = 1'b0;
      chk("rb_sw_writes", 32'(wr_cnt - w0), 32'd4);
      chk("rb_sw_mem", {rd(32'h403), rd(32'h402), rd(32'h401), rd(32'h400)}, 32'hDEADBEEF);

      // Flush together with the request: store kept, load dropped
      rollback = 1'b1;
      issue(`OPNUM_SB, 32'h410, 32'h0000005A, 5'd10, 1'b1);
      rollback = 1'b0;
      @(negedge clk); chk("rb_sb_accepted", {31'd0, full}, 32'd1);
      repeat (3) begin @(posedge clk); #1; end
      chk("rb_sb_mem", {24'd0, rd(32'h410)}, 32'h5A);
      v0 = vcnt;
      rollback = 1'b1;
      issue(`OPNUM_LW, 32'h200, 32'd0, 5'd11, 1'b0);
      rollback = 1'b0;
      @(negedge clk); chk("rb_ld_dropped", {31'd0, full}, 32'd0);
      repeat (8) begin @(posedge clk); #1; end
      chk("rb_ld_no_valid", 32'(vcnt - v0), 32'd0);

      // SB to the I/O region held while the I/O buffer is full in cycles 1-3
      w0 = wr_cnt;
      issue(`OPNUM_SB, 32'h30000, 32'h000000C3, 5'd12, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         io_full = (k <= 3);
         @(negedge clk);
         chk("io_wr_cyc", {31'd0, mem_wr}, 32'(k == 4));
         @(posedge clk); #1;
      end
      io_full = 1'b0;
      chk("io_writes", 32'(wr_cnt - w0), 32'd1);

      // Reset in cycle 2 of a SW: outputs clear at once, no later writes
      w0 = wr_cnt;
      keep = rd(32'h501);
      issue(`OPNUM_SW, 32'h500, 32'h11223344, 5'd13, 1'b0);
      exp_wr.push_back('{addr: 32'h500, data: 8'h44});
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk_reset_outs("rst_mid");
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      chk("rst_writes", 32'(wr_cnt - w0), 32'd1);
      chk("rst_mem_501", {24'd0, rd(32'h501)}, {24'd0, keep});

      // Random mix under random grant
      rnd_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         issue(6'($urandom_range(1, 8)), 32'h1000 + 32'($urandom_range(0, 255)),
               $urandom, 5'(i % 16), 1'b1);
      end
      wt = 0;
      while ((exp_ld.size() != 0 || exp_wr.size() != 0 || full) && wt < 500) begin
         @(posedge clk); #1; wt++;
      end
      chk("drain_ld", 32'(exp_ld.size()), 32'd0);
      chk("drain_wr", 32'(exp_wr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
